// File: rtl/spi_frame_rx_if.sv
// Serial pins and decoded frame/word stream of spi_frame_rx.
// The master modport is the host/bench side; the slave modport is the receiver.
interface spi_frame_rx_if #(
  parameter int LEN_W  = 8,
  parameter int WORD_W = 32,
  parameter int ID_W   = 8
);
  logic              CS_n;
  logic [3:0]        mosi;
  logic              miso;
  logic              busy;
  logic              frame_start;
  logic [3:0]        frame_op;
  logic [LEN_W-1:0]  frame_len;
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic [LEN_W-1:0]  word_idx;
  logic              word_last;
  logic              frame_end;
  logic [3:0]        frame_status;
  logic [ID_W-1:0]   frame_seq;

  modport master (
    output CS_n, mosi,
    input  miso, busy, frame_start, frame_op, frame_len, word_valid, word_data,
           word_idx, word_last, frame_end, frame_status, frame_seq
  );

  modport slave (
    input  CS_n, mosi,
    output miso, busy, frame_start, frame_op, frame_len, word_valid, word_data,
           word_idx, word_last, frame_end, frame_status, frame_seq
  );
endinterface

// File: rtl/spi_frame_rx.sv
// SPI/QSPI command-frame receiver: opcode, word count, payload words, status/sequence response on miso.
// Defining SPI_FRAME_CRC_EN adds a CRC-8 (poly 0x07) trailer after the payload.
module spi_frame_rx #(
  parameter int          LANES     = 4,
  parameter int          LEN_W     = 8,
  parameter int          WORD_W    = 32,
  parameter int          MAX_WORDS = 255,
  parameter int          ID_W      = 8,
  parameter int          TURN_CYC  = 2,
  parameter int          GUARD_CYC = 8,
  parameter logic [15:0] OP_MASK   = 16'h001E
) (
  input  logic          sck,
  input  logic          rst,
  spi_frame_rx_if.slave bus
);
  localparam int OP_BEATS   = 4 / LANES;
  localparam int LEN_BEATS  = LEN_W / LANES;
  localparam int WORD_BEATS = WORD_W / LANES;
  localparam int RESP_W     = 4 + ID_W;
  localparam int CNT_W      = $clog2(WORD_W + RESP_W + TURN_CYC + 1);
  localparam int GRD_W      = $clog2(GUARD_CYC + 1);

  localparam logic [3:0] ST_OK = 4'd0, ST_BAD_OP = 4'd1, ST_BAD_LEN = 4'd2,
                         ST_CRC_ERR = 4'd3, ST_ABORT = 4'd4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_OPC     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
`ifdef SPI_FRAME_CRC_EN
    S_CRC     = 3'd4,
`endif
    S_TURN    = 3'd5,
    S_RESP    = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t              state, state_nx, field;
  logic [GRD_W-1:0]    guard, guard_nx;
  logic [WORD_W-1:0]   sh, sh_nx, sh_in;
  logic [CNT_W-1:0]    cnt, cnt_nx, cnt_in;
  logic [LEN_W-1:0]    wcnt, wcnt_nx;
  logic [3:0]          op_hold, op_nx;
  logic [RESP_W-1:0]   resp_sh, resp_nx;
  logic [ID_W-1:0]     seq_cnt, seq_nx;
  logic [LANES-1:0]    beat;
  logic                miso_r, miso_nx, busy_r, busy_nx, start_r, start_nx;
  logic                wvld_r, wvld_nx, wlast_r, wlast_nx, fend_r, fend_nx;
  logic [3:0]          fop_r, fop_nx, fstat_r, fstat_nx, end_st;
  logic [LEN_W-1:0]    flen_r, flen_nx, widx_r, widx_nx;
  logic [WORD_W-1:0]   wdat_r, wdat_nx;
  logic [ID_W-1:0]     fseq_r, fseq_nx;
  logic                take, end_now, to_resp, to_turn, to_tail;

`ifdef SPI_FRAME_CRC_EN
  localparam int CRC_BEATS = 8 / LANES;
  logic [7:0] crc, crc_nx;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [LANES-1:0] b);
    logic [7:0] r;
    r = c;
    for (int i = LANES - 1; i >= 0; i--) r = {r[6:0], 1'b0} ^ ((r[7] ^ b[i]) ? 8'h07 : 8'h00);
    return r;
  endfunction
`endif

  // The first opcode beat is sampled by the IDLE edge that accepts the frame.
  assign beat   = bus.mosi[LANES-1:0];
  assign field  = (state == S_IDLE) ? S_OPC : state;
  assign sh_in  = (state == S_IDLE) ? WORD_W'(beat) : {sh[WORD_W-LANES-1:0], beat};
  assign cnt_in = (state == S_IDLE) ? CNT_W'(1) : cnt + 1'b1;

  always_comb begin
    state_nx = state;   guard_nx = guard;   sh_nx = sh;       cnt_nx = cnt;
    wcnt_nx  = wcnt;    op_nx    = op_hold; resp_nx = resp_sh; seq_nx = seq_cnt;
    miso_nx  = 1'b0;    start_nx = 1'b0;    wvld_nx = 1'b0;   fend_nx = 1'b0;
    fop_nx   = fop_r;   flen_nx  = flen_r;  wdat_nx = wdat_r; widx_nx = widx_r;
    wlast_nx = wlast_r; fstat_nx = fstat_r; fseq_nx = fseq_r;
    take = 1'b0; end_now = 1'b0; end_st = ST_OK; to_resp = 1'b0; to_turn = 1'b0; to_tail = 1'b0;
`ifdef SPI_FRAME_CRC_EN
    crc_nx = crc;
`endif

    case (state)
      S_IDLE: begin
        if (bus.CS_n) begin
          if (guard != GRD_W'(GUARD_CYC)) guard_nx = guard + 1'b1;
        end else begin
          guard_nx = '0;
          take     = (guard == GRD_W'(GUARD_CYC));
        end
      end
      S_TURN: begin
        if (bus.CS_n) state_nx = S_IDLE;
        else if (cnt == CNT_W'(TURN_CYC - 1)) to_resp = 1'b1;
        else cnt_nx = cnt + 1'b1;
      end
      S_RESP: begin
        if (bus.CS_n) state_nx = S_IDLE;
        else if (cnt == CNT_W'(RESP_W - 1)) state_nx = S_DONE;
        else begin
          cnt_nx  = cnt + 1'b1;
          resp_nx = {resp_sh[RESP_W-2:0], 1'b0};
          miso_nx = resp_sh[RESP_W-2];
        end
      end
      S_DONE: if (bus.CS_n) state_nx = S_IDLE;
      default: begin
        if (bus.CS_n) begin
          end_now  = 1'b1;
          end_st   = ST_ABORT;
          state_nx = S_IDLE;
        end else begin
          take = 1'b1;
        end
      end
    endcase

    if (take) begin
      sh_nx  = sh_in;
      cnt_nx = cnt_in;
`ifdef SPI_FRAME_CRC_EN
      if (field != S_CRC) crc_nx = crc_step((state == S_IDLE) ? 8'h00 : crc, beat);
`endif
      case (field)
        S_OPC: begin
          state_nx = S_OPC;
          if (cnt_in == CNT_W'(OP_BEATS)) begin
            cnt_nx = '0;
            op_nx  = sh_in[3:0];
            if (!OP_MASK[sh_in[3:0]]) begin
              end_now = 1'b1; end_st = ST_BAD_OP; to_resp = 1'b1;
            end else begin
              state_nx = S_LEN;
            end
          end
        end
        S_LEN: begin
          if (cnt_in == CNT_W'(LEN_BEATS)) begin
            cnt_nx = '0;
            if (int'(sh_in[LEN_W-1:0]) > MAX_WORDS) begin
              end_now = 1'b1; end_st = ST_BAD_LEN; to_resp = 1'b1;
            end else begin
              start_nx = 1'b1;
              fop_nx   = op_hold;
              flen_nx  = sh_in[LEN_W-1:0];
              wcnt_nx  = '0;
              if (sh_in[LEN_W-1:0] == '0) to_tail = 1'b1;
              else state_nx = S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (cnt_in == CNT_W'(WORD_BEATS)) begin
            cnt_nx   = '0;
            wvld_nx  = 1'b1;
            wdat_nx  = sh_in;
            widx_nx  = wcnt;
            wlast_nx = (wcnt == flen_r - 1'b1);
            wcnt_nx  = wcnt + 1'b1;
            to_tail  = (wcnt == flen_r - 1'b1);
          end
        end
`ifdef SPI_FRAME_CRC_EN
        S_CRC: begin
          if (cnt_in == CNT_W'(CRC_BEATS)) begin
            end_now = 1'b1;
            end_st  = (sh_in[7:0] == crc) ? ST_OK : ST_CRC_ERR;
            to_turn = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end

    if (to_tail) begin
`ifdef SPI_FRAME_CRC_EN
      state_nx = S_CRC;
      cnt_nx   = '0;
`else
      end_now = 1'b1; end_st = ST_OK; to_turn = 1'b1;
`endif
    end

    // Only OK frames advance the sequence; others report the unchanged count.
    if (end_now) begin
      fend_nx  = 1'b1;
      fstat_nx = end_st;
      fseq_nx  = (end_st == ST_OK) ? seq_cnt + 1'b1 : seq_cnt;
      seq_nx   = fseq_nx;
    end
    if (to_turn) begin
      state_nx = S_TURN;
      cnt_nx   = '0;
    end
    if (to_resp) begin
      state_nx = S_RESP;
      cnt_nx   = '0;
      resp_nx  = {fstat_nx, fseq_nx};
      miso_nx  = fstat_nx[3];
    end
    busy_nx = (state_nx != S_IDLE);
  end

  always_ff @(posedge sck) begin
    if (rst) begin
      state <= S_IDLE;  guard <= '0;   sh <= '0;     cnt <= '0;    wcnt <= '0;
      op_hold <= '0;    resp_sh <= '0; seq_cnt <= '0;
      miso_r <= 1'b0;   busy_r <= 1'b0; start_r <= 1'b0; wvld_r <= 1'b0;
      wlast_r <= 1'b0;  fend_r <= 1'b0; fop_r <= '0;    fstat_r <= '0;
      flen_r <= '0;     widx_r <= '0;   wdat_r <= '0;   fseq_r <= '0;
    end else begin
      state <= state_nx;  guard <= guard_nx;  sh <= sh_nx;      cnt <= cnt_nx;  wcnt <= wcnt_nx;
      op_hold <= op_nx;   resp_sh <= resp_nx; seq_cnt <= seq_nx;
      miso_r <= miso_nx;  busy_r <= busy_nx;  start_r <= start_nx; wvld_r <= wvld_nx;
      wlast_r <= wlast_nx; fend_r <= fend_nx; fop_r <= fop_nx;   fstat_r <= fstat_nx;
      flen_r <= flen_nx;  widx_r <= widx_nx;  wdat_r <= wdat_nx; fseq_r <= fseq_nx;
    end
  end

`ifdef SPI_FRAME_CRC_EN
  always_ff @(posedge sck) begin
    if (rst) crc <= '0;
    else     crc <= crc_nx;
  end
`endif

  assign bus.miso         = miso_r;
  assign bus.busy         = busy_r;
  assign bus.frame_start  = start_r;
  assign bus.frame_op     = fop_r;
  assign bus.frame_len    = flen_r;
  assign bus.word_valid   = wvld_r;
  assign bus.word_data    = wdat_r;
  assign bus.word_idx     = widx_r;
  assign bus.word_last    = wlast_r;
  assign bus.frame_end    = fend_r;
  assign bus.frame_status = fstat_r;
  assign bus.frame_seq    = fseq_r;
endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed-vector bench for spi_frame_rx: stimulus pushes expected events into queues,
// a negedge monitor pops and compares frame_start, word_valid, frame_end and the miso response.
module tb_spi_frame_rx;
  localparam int TURN_CYC = 2;
  localparam int MAX_W    = 16;

  logic sck = 1'b0;
  logic rst;
  always #5 sck = ~sck;

  spi_frame_rx_if #(.LEN_W(8), .WORD_W(32), .ID_W(8)) bus ();

  spi_frame_rx #(.MAX_WORDS(MAX_W), .TURN_CYC(TURN_CYC)) dut (
    .sck (sck),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          coll  = 1'b0;
  logic [7:0]  exp_seq = 8'd0;
  logic [31:0] wbuf [0:15];
  logic [11:0] q_start [$];
  logic [40:0] q_word  [$];
  logic [11:0] q_end   [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic beat(input logic [3:0] b);
    bus.CS_n = 1'b0;
    bus.mosi = b;
    @(posedge sck); #1;
  endtask

  task automatic idle(input int n);
    bus.CS_n = 1'b1;
    bus.mosi = 4'h0;
    repeat (n) begin @(posedge sck); #1; end
  endtask

`ifdef SPI_FRAME_CRC_EN
  function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic [31:0] v, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) c = {c[6:0], 1'b0} ^ ((c[7] ^ v[i]) ? 8'h07 : 8'h00);
    return c;
  endfunction
`endif

  // st is the hand-assigned expected status; npay is the number of payload beats actually sent.
  task automatic send_frame(input logic [3:0] op, input logic [7:0] len, input int npay,
                            input logic [3:0] st, input bit flip);
    logic [31:0] w;
    logic [7:0]  c;
    if (st == 4'd0) exp_seq++;
    if (st != 4'd1 && st != 4'd2) q_start.push_back({op, len});
    if (st == 4'd0 || st == 4'd3)
      for (int i = 0; i < int'(len); i++) q_word.push_back({wbuf[i], 8'(i), (i == int'(len) - 1)});
    q_end.push_back({st, exp_seq});
    beat(op);
    beat(len[7:4]);
    beat(len[3:0]);
    for (int b = 0; b < npay; b++) begin
      w = wbuf[b / 8];
      beat(w[31 - 4 * (b % 8) -: 4]);
    end
    c = 8'h00;
`ifdef SPI_FRAME_CRC_EN
    if (st == 4'd0 || st == 4'd3) begin
      c = crc_upd(c, {28'h0, op}, 4);
      c = crc_upd(c, {24'h0, len}, 8);
      for (int i = 0; i < int'(len); i++) c = crc_upd(c, wbuf[i], 32);
      if (flip) c[0] = ~c[0];
      beat(c[7:4]);
      beat(c[3:0]);
    end
`endif
    if (st == 4'd4) begin
      check("busy before abort", 64'(bus.busy), 64'd1);
      idle(1);
      check("busy after abort", 64'(bus.busy), 64'd0);
    end else begin
      repeat (16) beat(4'h0);
    end
  endtask

  // Monitor: compares every DUT pulse against the head of its queue and collects responses.
  initial begin
    logic [11:0] e, acc, exp_resp;
    logic [40:0] ew;
    int          k, wait_c;
    acc = '0; exp_resp = '0; k = 0; wait_c = 0;
    forever begin
      @(negedge sck);
      if (!rst) begin
        if (bus.frame_start) begin
          if (q_start.size() == 0) check("spurious frame_start", 64'(bus.frame_start), 64'd0);
          else begin
            e = q_start.pop_front();
            check("frame_start op/len", 64'({bus.frame_op, bus.frame_len}), 64'(e));
          end
        end
        if (bus.word_valid) begin
          if (q_word.size() == 0) check("spurious word_valid", 64'(bus.word_valid), 64'd0);
          else begin
            ew = q_word.pop_front();
            check("word data/idx/last", 64'({bus.word_data, bus.word_idx, bus.word_last}), 64'(ew));
          end
        end
        if (bus.frame_end) begin
          if (q_end.size() == 0) check("spurious frame_end", 64'(bus.frame_end), 64'd0);
          else begin
            e = q_end.pop_front();
            check("frame_end status/seq", 64'({bus.frame_status, bus.frame_seq}), 64'(e));
            if (e[11:8] != 4'd4) begin
              coll = 1'b1; exp_resp = e; k = 0; acc = '0;
              wait_c = (e[11:8] == 4'd1 || e[11:8] == 4'd2) ? 0 : TURN_CYC;
            end
          end
        end
        if (coll) begin
          if (wait_c > 0) wait_c--;
          else begin
            acc = {acc[10:0], bus.miso};
            k++;
            if (k == 12) begin
              check("miso response", 64'(acc), 64'(exp_resp));
              coll = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: stimulus did not complete, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.CS_n = 1'b1;
    bus.mosi = 4'h0;
    repeat (3) @(posedge sck);
    #1;
    check("reset flags", 64'({bus.busy, bus.miso, bus.frame_start, bus.word_valid, bus.frame_end}), 64'd0);
    check("reset frame fields", 64'({bus.frame_op, bus.frame_len, bus.frame_status, bus.frame_seq}), 64'd0);
    check("reset word fields", 64'({bus.word_data, bus.word_idx}), 64'd0);
    rst = 1'b0;
    idle(12);

    send_frame(4'h0, 8'h00, 0, 4'd1, 1'b0);    // illegal opcode -> 0x1_00
    idle(12);
    send_frame(4'h1, 8'h11, 0, 4'd2, 1'b0);    // 17 > MAX_WORDS -> 0x2_00
    idle(12);

    wbuf[0] = 32'hDEADBEEF;
    wbuf[1] = 32'h01234567;
    send_frame(4'h1, 8'h02, 16, 4'd0, 1'b0);   // OK -> 0x0_01
    idle(12);
    send_frame(4'h2, 8'h02, 5, 4'd4, 1'b0);    // abort inside word 0
    idle(12);

    send_frame(4'h3, 8'h00, 0, 4'd0, 1'b0);    // zero-length OK -> 0x0_02
    idle(3);
    beat(4'h1); beat(4'h0); beat(4'h2);
    repeat (8) beat(4'h0);
    check("busy after short guard", 64'(bus.busy), 64'd0);
    idle(12);

    for (int i = 0; i < MAX_W; i++) wbuf[i] = {4{8'(i)}} ^ 32'hA5A5_0000;
    send_frame(4'h4, 8'(MAX_W), 8 * MAX_W, 4'd0, 1'b0);  // longest legal frame -> 0x0_03
    idle(12);

`ifdef SPI_FRAME_CRC_EN
    wbuf[0] = 32'hDEADBEEF;
    wbuf[1] = 32'h01234567;
    send_frame(4'h1, 8'h02, 16, 4'd0, 1'b0);   // good CRC -> 0x0_04
    idle(12);
    send_frame(4'h1, 8'h02, 16, 4'd3, 1'b1);   // flipped CRC bit -> 0x3_04
    idle(12);
`endif

    repeat (5) @(posedge sck);
    #1;
    check("frame_start events outstanding", 64'(q_start.size()), 64'd0);
    check("word events outstanding", 64'(q_word.size()), 64'd0);
    check("frame_end events outstanding", 64'(q_end.size()), 64'd0);
    check("response still collecting", 64'(coll), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_frame_rx.md
# spi_frame_rx

Parametrised SPI/QSPI command-frame receiver, the generalised successor of the fixed-opcode SPI driver. It deserialises host frames of the form opcode, word count, payload words and optional CRC, and streams payload words to the raster-memory loaders. It returns a status/sequence response on `miso` and handles chip-select abort and guard timing. Lane count, field widths and depth are set by parameters; per-opcode semantics live downstream.

## Interface
- `LANES`, 4: data lanes used on `mosi` (1, 2 or 4); every field width must be a multiple of `LANES`.
- `LEN_W`, 8: width of the word-count field.
- `WORD_W`, 32: payload word width.
- `MAX_WORDS`, 255: largest legal word count.
- `ID_W`, 8: sequence-counter width.
- `TURN_CYC`, 2: dummy cycles between payload and response.
- `GUARD_CYC`, 8: consecutive `CS_n`-high cycles required before a frame is accepted.
- `OP_MASK`, 16'h001E: bit n set means opcode n is legal.

Ports:
- `sck` in 1: free-running serial clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `CS_n` in 1: chip select, active-low, synchronous to `sck`.
- `mosi` in 4: data; only bits `[LANES-1:0]` are used, MSB-first.
- `miso` out 1: response bit.
- `busy` out 1: frame in progress (any state except IDLE).
- `frame_start` out 1: pulse, header accepted.
- `frame_op` out 4: opcode, held until the next `frame_start`.
- `frame_len` out LEN_W: word count, held until the next `frame_start`.
- `word_valid` out 1: pulse, payload word complete.
- `word_data` out WORD_W: payload word.
- `word_idx` out LEN_W: index of the word, 0-based.
- `word_last` out 1: qualifies the final word.
- `frame_end` out 1: pulse, frame outcome known.
- `frame_status` out 4: 0 OK, 1 INVALID_OPCODE, 2 BAD_LEN, 3 CRC_ERR, 4 ABORTED.
- `frame_seq` out ID_W: sequence number reported in the response.

## Operation
- States: IDLE, OPC, LEN, PAYLOAD, CRC (macro only), TURN, RESP, DONE.
- Every rising edge while `CS_n` is low shifts `LANES` bits into the active field.
- A field of width F takes F/`LANES` cycles.
- IDLE:
  - The guard counter counts `CS_n`-high cycles, saturating at `GUARD_CYC`.
  - `CS_n` low with guard saturated: enter OPC and sample the first beat.
  - `CS_n` low before saturation: stay in IDLE and clear the counter.
- OPC:
  - If the opcode bit in `OP_MASK` is clear: status 1, enter RESP.
  - Otherwise enter LEN.
- LEN:
  - Count > `MAX_WORDS`: status 2, enter RESP.
  - Otherwise pulse `frame_start`.
  - Count 0: go to CRC or TURN.
  - Otherwise go to PAYLOAD.
- PAYLOAD:
  - Pulse `word_valid` per word; `word_idx` increments.
  - `word_last` is high when `word_idx == frame_len-1`.
  - No backpressure exists; the consumer must accept one word per `WORD_W`/`LANES` cycles.
- TURN: `TURN_CYC` cycles, `miso` = 0. Pulse `frame_end` on entry with the final status.
- RESP:
  - Shift `{frame_status, frame_seq}` MSB-first, one bit per cycle, 4+`ID_W` cycles.
  - On error entry, `frame_end` pulses on RESP entry instead.
- DONE: `miso` = 0 and `mosi` is ignored until `CS_n` goes high, then return to IDLE.
- Sequence counter:
  - Increments on each OK `frame_end`.
  - `frame_seq` is the post-increment value for OK frames and the unchanged counter value otherwise.
- Abort: `CS_n` high in OPC, LEN, PAYLOAD or CRC gives `frame_end` with status 4 and a return to IDLE. No `word_valid` is issued for a partial word.
- `CS_n` high in TURN or RESP: return to IDLE without a second `frame_end`.
- Word count arithmetic is unsigned `LEN_W`; the word index never wraps because count ≤ `MAX_WORDS`.

## Timing
- Reset values:
  - All pulse outputs, `busy` and `miso`: 0.
  - `frame_op`, `frame_len`, `word_data`, `word_idx`, `frame_status`, `frame_seq`: 0.
  - Sequence counter: 0.
  - Guard counter: 0.
  - State: IDLE.
- Reset asserted mid-frame discards the frame silently (no `frame_end`).
- Outputs are registered. A pulse is high for exactly the one cycle following the edge that sampled the completing beat.
- `miso` changes after a rising edge; the host samples it on the next rising edge.
- Response bit k appears the cycle after RESP entry + k.
- `word_data` holds its value until the next word completes.

## Configuration
- `SPI_FRAME_CRC_EN` defined:
  - An 8-bit CRC field follows the payload.
  - Polynomial 0x07, init 0x00, computed over opcode, LEN and payload bits in wire order.
  - A mismatch gives status 3 and no sequence increment.
  - Words are already streamed, so the consumer discards the frame on a non-OK `frame_end`.
  - `LANES` must divide 8.
- Undefined: the CRC state is absent; PAYLOAD or LEN go directly to TURN.

## Test plan
- Defaults, `GUARD_CYC` high cycles, op 0x1, LEN 0x02, words 0xDEADBEEF and 0x01234567:
  - Two `word_valid` pulses, idx 0 then 1, `word_last` on the second.
  - `frame_end` status 0.
  - `miso` shifts 0x0_01.
- Op 0x0: `frame_end` status 1 after 1 cycle; `miso` shifts 0x1_00; no `frame_start`; counter unchanged.
- `MAX_WORDS`=16, LEN 0x11: status 2; no `word_valid`; `miso` 0x2_00.
- `CS_n` raised after 5 of 8 beats of word 0: `frame_end` status 4, no `word_valid`, `busy` 0 next cycle.
- `CS_n` low only 3 cycles after the previous frame (guard 8): frame ignored, no `frame_start`.
- With `SPI_FRAME_CRC_EN`, correct CRC gives status 0; a flipped CRC bit gives status 3 with `frame_seq` unchanged.
